i2c_codec_target: RTL and testbench

Synthesizable I2C target (responder) that models the audio codec's write-only control port. It watches the shared SCL/SDA lines driven by the codec initializer and decodes each 3-byte write frame: device address, then 7-bit register index plus 9-bit data. It ACKs by pulling SDA low and commits the write into a local register file. It serves as the on-chip loopback partner of the initializer for bring-up and verification, and as a snoop/shadow copy of codec configuration.

---
 rtl/i2c_codec_target_if.sv | 23 ++
 rtl/i2c_codec_target.sv | 202 ++++++++++++++++++++
 tb/tb_i2c_codec_target.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_codec_target_if.sv
// Bus and register-port bundle for the codec control-port I2C target.
interface i2c_codec_target_if;
  logic       i_scl;
  logic       i_sda;
  logic       o_sda_pull;
  logic       o_wr_valid;
  logic [6:0] o_wr_addr;
  logic [8:0] o_wr_data;
  logic [6:0] i_rd_addr;
  logic [8:0] o_rd_data;
  logic       o_frame_err;
  logic       o_busy;

  modport slave (
    input  i_scl, i_sda, i_rd_addr,
    output o_sda_pull, o_wr_valid, o_wr_addr, o_wr_data, o_rd_data, o_frame_err, o_busy
  );

  modport master (
    output i_scl, i_sda, i_rd_addr,
    input  o_sda_pull, o_wr_valid, o_wr_addr, o_wr_data, o_rd_data, o_frame_err, o_busy
  );
endinterface

// File: rtl/i2c_codec_target.sv
// Write-only I2C target shadowing codec registers: addr byte, {reg[6:0],d8}, d[7:0].
// Define I2C_TGT_SYNC_EN to add 2-flop synchronizers on SCL/SDA for external pins.
module i2c_codec_target #(
  parameter logic [6:0]  DEV_ADDR = 7'h1A,
  parameter int unsigned NUM_REGS = 16
) (
  input logic               i_clk,
  input logic               i_rst,
  i2c_codec_target_if.slave bus
);
  localparam int unsigned IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0]  NUM_REGS_W = 8'(NUM_REGS);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_ACK, S_ACK_PULL, S_ACK_HOLD, S_WAIT
  } state_e;

  logic scl_s, sda_s;
`ifdef I2C_TGT_SYNC_EN
  logic [1:0] scl_sync_q, sda_sync_q;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], bus.i_scl};
      sda_sync_q <= {sda_sync_q[0], bus.i_sda};
    end
  end
  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];
`else
  assign scl_s = bus.i_scl;
  assign sda_s = bus.i_sda;
`endif

  state_e     state_q, state_d;
  logic       scl_q, sda_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [1:0] byte_idx_q, byte_idx_d;
  logic [6:0] shift_q, shift_d;
  logic [6:0] reg_q, reg_d;
  logic       d8_q, d8_d;
  logic [7:0] dlo_q, dlo_d;
  logic       pull_q, pull_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;
  logic       wr_valid_q, wr_valid_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic [8:0] wr_data_q, wr_data_d;
  logic [8:0] rd_data_q;
  logic [8:0] regs_q [NUM_REGS];
  logic       commit;
  logic [7:0] byte_val;

  // Sample copies reset high so reset release on an idle bus never looks like START.
  wire start_det = scl_s & scl_q & sda_q & ~sda_s;
  wire stop_det  = scl_s & scl_q & ~sda_q & sda_s;
  wire scl_rise  = scl_s & ~scl_q;
  wire scl_fall  = ~scl_s & scl_q;
  wire partial   = (byte_idx_q == 2'd1) || (byte_idx_q == 2'd2);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    reg_d      = reg_q;
    d8_d       = d8_q;
    dlo_d      = dlo_q;
    pull_d     = pull_q;
    busy_d     = busy_q;
    err_d      = 1'b0;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    commit     = 1'b0;
    byte_val   = {shift_q, sda_s};
    if (stop_det) begin
      state_d    = S_IDLE;
      pull_d     = 1'b0;
      busy_d     = 1'b0;
      err_d      = partial;
      byte_idx_d = '0;
    end else if (start_det) begin
      state_d    = S_ADDR;
      pull_d     = 1'b0;
      busy_d     = 1'b1;
      err_d      = partial;
      bit_cnt_d  = '0;
      byte_idx_d = '0;
    end else begin
      unique case (state_q)
        S_ADDR, S_DATA: begin
          if (scl_rise) begin
            shift_d   = byte_val[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = S_WAIT;
              pull_d  = 1'b0;
              unique case (byte_idx_q)
                2'd0: begin
                  if (byte_val[7:1] == DEV_ADDR) begin
                    if (!byte_val[0]) state_d = S_ACK;
                    else              err_d   = 1'b1;
                  end
                end
                2'd1: begin
                  if ({1'b0, byte_val[7:1]} < NUM_REGS_W) begin
                    state_d = S_ACK;
                    reg_d   = byte_val[7:1];
                    d8_d    = byte_val[0];
                  end else begin
                    err_d = 1'b1;
                  end
                end
                2'd2: begin
                  state_d = S_ACK;
                  dlo_d   = byte_val;
                end
                default: err_d = 1'b1;
              endcase
            end
          end
        end
        S_ACK: begin
          if (scl_fall) begin
            pull_d  = 1'b1;
            state_d = S_ACK_PULL;
          end
        end
        S_ACK_PULL: begin
          if (scl_rise) state_d = S_ACK_HOLD;
        end
        S_ACK_HOLD: begin
          if (scl_fall) begin
            pull_d     = 1'b0;
            byte_idx_d = byte_idx_q + 2'd1;
            bit_cnt_d  = '0;
            state_d    = S_DATA;
            if (byte_idx_q == 2'd2) begin
              commit     = 1'b1;
              wr_valid_d = 1'b1;
              wr_addr_d  = reg_q;
              wr_data_d  = {d8_q, dlo_q};
            end
          end
        end
        S_WAIT:  pull_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      reg_q      <= '0;
      d8_q       <= 1'b0;
      dlo_q      <= '0;
      pull_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_data_q  <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      scl_q      <= scl_s;
      sda_q      <= sda_s;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      reg_q      <= reg_d;
      d8_q       <= d8_d;
      dlo_q      <= dlo_d;
      pull_q     <= pull_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_data_q  <= ({1'b0, bus.i_rd_addr} < NUM_REGS_W) ? regs_q[bus.i_rd_addr[IDX_W-1:0]] : '0;
      if (commit) regs_q[reg_q[IDX_W-1:0]] <= {d8_q, dlo_q};
    end
  end

  assign bus.o_sda_pull  = pull_q;
  assign bus.o_wr_valid  = wr_valid_q;
  assign bus.o_wr_addr   = wr_addr_q;
  assign bus.o_wr_data   = wr_data_q;
  assign bus.o_rd_data   = rd_data_q;
  assign bus.o_frame_err = err_q;
  assign bus.o_busy      = busy_q;
endmodule

// File: tb/tb_i2c_codec_target.sv
// Scoreboard bench for i2c_codec_target: bit-banged write frames, queued expected commits.
module tb_i2c_codec_target;
  logic clk = 1'b0;
  logic rst;
  logic m_sda;

  i2c_codec_target_if bus ();

  i2c_codec_target #(.DEV_ADDR(7'h1A), .NUM_REGS(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  assign bus.i_sda = m_sda & ~bus.o_sda_pull;

  typedef struct { logic [6:0] addr; logic [8:0] data; } wr_t;
  wr_t wr_q [$];

  int n_cmp = 0;
  int n_bad = 0;
  int err_seen = 0;
  int exp_err = 0;
  int pull_seen = 0;
  logic err_prev = 1'b0;
  logic pull_prev = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the commit scoreboard and tracks err/pull pulses.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus.o_wr_valid) begin
        if (wr_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, expected no commit",
                   bus.o_wr_addr, bus.o_wr_data);
        end else begin
          e = wr_q.pop_front();
          check("wr_addr", int'(bus.o_wr_addr), int'(e.addr));
          check("wr_data", int'(bus.o_wr_data), int'(e.data));
        end
      end
      if (err_prev) check("err_pulse_width", int'(bus.o_frame_err), 0);
      if (bus.o_frame_err && !err_prev) err_seen++;
      if (bus.o_sda_pull && !pull_prev) pull_seen++;
      err_prev  = bus.o_frame_err;
      pull_prev = bus.o_sda_pull;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;     wait_clk(4);
    bus.i_scl = 1'b1; wait_clk(4);
    m_sda = 1'b0;     wait_clk(4);
    bus.i_scl = 1'b0; wait_clk(1);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;     wait_clk(4);
    bus.i_scl = 1'b1; wait_clk(4);
    m_sda = 1'b1;     wait_clk(4);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i >= 8 - n; i--) begin
      m_sda = b[i];     wait_clk(4);
      bus.i_scl = 1'b1; wait_clk(4);
      bus.i_scl = 1'b0; wait_clk(1);
    end
  endtask

  task automatic ack_slot(output logic ack);
    m_sda = 1'b1;     wait_clk(3);
    bus.i_scl = 1'b1; wait_clk(2);
    ack = ~bus.i_sda; wait_clk(2);
    bus.i_scl = 1'b0; wait_clk(1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string nm);
    logic a;
    send_bits(b, 8);
    ack_slot(a);
    check(nm, int'(a), int'(exp_ack));
  endtask

  task automatic rd_check(input logic [6:0] a, input logic [8:0] exp, input string nm);
    bus.i_rd_addr = a;
    wait_clk(1);
    check(nm, int'(bus.o_rd_data), int'(exp));
  endtask

  initial begin
    int ps;
    logic got;
    rst = 1'b1;
    bus.i_scl = 1'b1;
    m_sda = 1'b1;
    bus.i_rd_addr = '0;
    wait_clk(4);
    check("rst_sda_pull", int'(bus.o_sda_pull), 0);
    check("rst_wr_valid", int'(bus.o_wr_valid), 0);
    check("rst_rd_data", int'(bus.o_rd_data), 0);
    check("rst_frame_err", int'(bus.o_frame_err), 0);
    check("rst_busy", int'(bus.o_busy), 0);
    rst = 1'b0;
    wait_clk(4);

    // Register 15 written with data 0.
    i2c_start();
    check("t1_busy", int'(bus.o_busy), 1);
    wr_q.push_back('{7'h0F, 9'h000});
    send_byte(8'h34, 1'b1, "t1_ack0");
    send_byte(8'h1E, 1'b1, "t1_ack1");
    send_byte(8'h00, 1'b1, "t1_ack2");
    i2c_stop();
    wait_clk(2);

    // Register 4 = 0x015, read back, busy low after STOP.
    i2c_start();
    wr_q.push_back('{7'h04, 9'h015});
    send_byte(8'h34, 1'b1, "t2_ack0");
    send_byte(8'h08, 1'b1, "t2_ack1");
    send_byte(8'h15, 1'b1, "t2_ack2");
    i2c_stop();
    wait_clk(2);
    check("t2_busy_after_stop", int'(bus.o_busy), 0);
    rd_check(7'd4, 9'h015, "t2_rd4");

    // Foreign address: silent, then a normal frame to reg 7 = 0x1A9.
    ps = pull_seen;
    i2c_start();
    send_byte(8'h36, 1'b0, "t3_foreign_ack0");
    send_byte(8'h0A, 1'b0, "t3_foreign_ack1");
    send_byte(8'h55, 1'b0, "t3_foreign_ack2");
    i2c_stop();
    wait_clk(2);
    check("t3_no_pull", pull_seen, ps);
    check("t3_no_err", err_seen, exp_err);
    i2c_start();
    wr_q.push_back('{7'h07, 9'h1A9});
    send_byte(8'h34, 1'b1, "t3_ack0");
    send_byte(8'h0F, 1'b1, "t3_ack1");
    send_byte(8'hA9, 1'b1, "t3_ack2");
    i2c_stop();
    wait_clk(2);
    rd_check(7'd7, 9'h1A9, "t3_rd7");

    // Reg 5 = 0x13C, then a truncated frame to reg 5 must leave it alone.
    i2c_start();
    wr_q.push_back('{7'h05, 9'h13C});
    send_byte(8'h34, 1'b1, "t4_ack0");
    send_byte(8'h0B, 1'b1, "t4_ack1");
    send_byte(8'h3C, 1'b1, "t4_ack2");
    i2c_stop();
    i2c_start();
    send_byte(8'h34, 1'b1, "t4p_ack0");
    send_byte(8'h0A, 1'b1, "t4p_ack1");
    i2c_stop();
    exp_err++;
    wait_clk(2);
    check("t4_err_count", err_seen, exp_err);
    rd_check(7'd5, 9'h13C, "t4_rd5");

    // Extra 4th byte is NACKed after the commit.
    i2c_start();
    wr_q.push_back('{7'h06, 9'h001});
    send_byte(8'h34, 1'b1, "t5_ack0");
    send_byte(8'h0C, 1'b1, "t5_ack1");
    send_byte(8'h01, 1'b1, "t5_ack2");
    send_byte(8'hFF, 1'b0, "t5_ack3");
    exp_err++;
    i2c_stop();
    wait_clk(2);
    check("t5_err_count", err_seen, exp_err);
    rd_check(7'd6, 9'h001, "t5_rd6");

    // Repeated START mid-byte1, then reg 8 = 0x077.
    i2c_start();
    send_byte(8'h34, 1'b1, "t6_ack0");
    send_bits(8'h0E, 4);
    i2c_start();
    exp_err++;
    wr_q.push_back('{7'h08, 9'h077});
    send_byte(8'h34, 1'b1, "t6_ack0b");
    send_byte(8'h10, 1'b1, "t6_ack1");
    send_byte(8'h77, 1'b1, "t6_ack2");
    i2c_stop();
    wait_clk(2);
    check("t6_err_count", err_seen, exp_err);
    rd_check(7'd8, 9'h077, "t6_rd8");

    // Top register index, and an out-of-range read.
    i2c_start();
    wr_q.push_back('{7'h0F, 9'h1FF});
    send_byte(8'h34, 1'b1, "t7_ack0");
    send_byte(8'h1F, 1'b1, "t7_ack1");
    send_byte(8'hFF, 1'b1, "t7_ack2");
    i2c_stop();
    wait_clk(2);
    rd_check(7'd15, 9'h1FF, "t7_rd15");
    rd_check(7'h50, 9'h000, "t7_rd_oor");
    check("t7_queue_drained", wr_q.size(), 0);

    // Reset during the address ACK slot.
    i2c_start();
    send_bits(8'h34, 8);
    m_sda = 1'b1;
    for (int i = 0; i < 12 && !bus.o_sda_pull; i++) @(negedge clk);
    got = bus.o_sda_pull;
    check("t8_ack_pull_seen", int'(got), 1);
    #2 rst = 1'b1;
    #1 check("t8_async_release", int'(bus.o_sda_pull), 0);
    bus.i_scl = 1'b1;
    m_sda = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(10);
    check("t8_no_spurious_busy", int'(bus.o_busy), 0);
    check("t8_no_spurious_err", err_seen, exp_err);
    rd_check(7'd4, 9'h000, "t8_regfile_cleared");

    check("final_queue_drained", wr_q.size(), 0);
    check("final_err_count", err_seen, exp_err);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
